// File: rtl/scroll_msg_writer.sv
// scroll_msg_writer: write-side controller for the scrolling message BRAM.
// Collects switch words on enter pulses, writes them sequentially to port A,
// publishes the committed length on exit, and can zero-fill the whole memory.
module scroll_msg_writer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_req,
  input  logic                  enter_tick,
  input  logic                  clear_req,
  input  logic [DATA_W-1:0]     sw_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic [DEPTH_LOG2:0]   msg_len,
  output logic                  len_valid,
  output logic                  prog_active,
  output logic                  busy,
  output logic                  full,
  output logic [DATA_W-1:0]     led
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Pointer is one bit wider than the address so "memory full" is representable.
  localparam logic [DEPTH_LOG2:0] PTR_MAX  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROG   = 3'd1,
    S_WRITE  = 3'd2,
    S_COMMIT = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [DEPTH_LOG2:0] wr_ptr, wr_ptr_n;
  logic [DATA_W-1:0]   hold, hold_n;
  logic [DEPTH_LOG2:0] msg_len_n;
  logic                len_valid_n;

  // State and datapath registers; async reset drops everything back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      hold      <= '0;
      msg_len   <= '0;
      len_valid <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      hold      <= hold_n;
      msg_len   <= msg_len_n;
      len_valid <= len_valid_n;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    hold_n      = hold;
    msg_len_n   = msg_len;
    len_valid_n = len_valid;
    case (state)
      S_IDLE: begin
        // Clear wins over a simultaneous programming request.
        if (clear_req) begin
          state_n  = S_CLEAR;
          wr_ptr_n = '0;
        end else if (prog_req) begin
          state_n  = S_PROG;
          wr_ptr_n = '0;
        end
      end
      S_PROG: begin
        // A word entered in the same cycle prog_req drops is still stored.
        if (enter_tick && (wr_ptr != PTR_MAX)) begin
          hold_n  = sw_data;
          state_n = S_WRITE;
        end else if (!prog_req) begin
          state_n = S_COMMIT;
        end
      end
      S_WRITE: begin
        wr_ptr_n = wr_ptr + 1'b1;
        state_n  = S_PROG;
      end
      S_COMMIT: begin
        // An empty session keeps the previously committed message.
        if (wr_ptr != '0) begin
          msg_len_n   = wr_ptr;
          len_valid_n = 1'b1;
        end
        state_n = S_IDLE;
      end
      S_CLEAR: begin
        wr_ptr_n = wr_ptr + 1'b1;
        if (wr_ptr == PTR_LAST) begin
          msg_len_n   = '0;
          len_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode from registered state and pointer only.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    prog_active = (state == S_PROG) || (state == S_WRITE);
    busy        = (state == S_WRITE) || (state == S_CLEAR) || (state == S_COMMIT);
    full        = prog_active && (wr_ptr == PTR_MAX);
    if (state == S_WRITE) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = wr_ptr[DEPTH_LOG2-1:0];
      mem_din  = hold;
    end else if (state == S_CLEAR) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = wr_ptr[DEPTH_LOG2-1:0];
    end
    // Thermometer: one lit LED per word stored this session.
    for (int i = 0; i < DATA_W; i++) begin
      led[i] = prog_active && (i < int'(wr_ptr));
    end
  end

endmodule

// File: tb/tb_scroll_msg_writer.sv
// Scoreboard bench for scroll_msg_writer: expected BRAM writes are queued as
// stimulus is issued and checked by a negedge monitor; status outputs are
// compared directly against hand-computed values.
module tb_scroll_msg_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_req = 1'b0;
  logic        enter_tick = 1'b0;
  logic        clear_req = 1'b0;
  logic [15:0] sw_data = '0;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_din;
  logic [4:0]  msg_len;
  logic        len_valid, prog_active, busy, full;
  logic [15:0] led;

  int nvec = 0;
  int nfail = 0;
  int exp_ptr = 0;
  logic [19:0] exp_q[$];

  scroll_msg_writer #(.DEPTH_LOG2(4), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .prog_req(prog_req), .enter_tick(enter_tick),
    .clear_req(clear_req), .sw_data(sw_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .msg_len(msg_len),
    .len_valid(len_valid), .prog_active(prog_active), .busy(busy),
    .full(full), .led(led)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!reset && mem_we) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e || mem_en !== 1'b1) begin
          nfail++;
          $display("FAIL write: addr=%0d data=%h en=%b, required addr=%0d data=%h en=1",
                   mem_addr, mem_din, mem_en, e[19:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic start_prog();
    prog_req = 1'b1;
    exp_ptr = 0;
    tick();
    chk("prog_active_on", {31'd0, prog_active}, 32'd1);
  endtask

  // Enter one word; the expected write is queued only when room remains.
  task automatic enter(input logic [15:0] d, input logic drop_prog);
    sw_data = d;
    enter_tick = 1'b1;
    if (drop_prog) prog_req = 1'b0;
    if (exp_ptr < 16) begin
      exp_q.push_back({4'(exp_ptr), d});
      exp_ptr++;
    end
    tick();
    enter_tick = 1'b0;
    tick();
    tick();
  endtask

  task automatic exit_prog();
    prog_req = 1'b0;
    tick();
    chk("commit_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_prog_active", {31'd0, prog_active}, 32'd0);
  endtask

  // Clear from IDLE, expect 16 zero writes and a return to IDLE 17 cycles on.
  task automatic run_clear();
    int n;
    for (int a = 0; a < 16; a++) exp_q.push_back({4'(a), 16'h0000});
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    prog_req = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd1);
    chk("clear_not_prog", {31'd0, prog_active}, 32'd0);
    n = 1;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd17);
    chk("clear_msg_len", {27'd0, msg_len}, 32'd0);
    chk("clear_len_valid", {31'd0, len_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outs", {mem_en, mem_we, mem_addr, mem_din, msg_len, len_valid,
                       prog_active, busy, full, led}, '0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {mem_en, mem_we, mem_addr, mem_din, msg_len, len_valid,
                        prog_active, busy, full, led}, '0);
    end

    // Three-word message
    start_prog();
    enter(16'h1234, 1'b0);
    chk("led_1", {16'd0, led}, 32'h0001);
    enter(16'hABCD, 1'b0);
    enter(16'h00FF, 1'b0);
    chk("led_3", {16'd0, led}, 32'h0007);
    chk("not_full_3", {31'd0, full}, 32'd0);
    exit_prog();
    chk("msg_len_3", {27'd0, msg_len}, 32'd3);
    chk("len_valid_3", {31'd0, len_valid}, 32'd1);

    // Seventeen enters: the last one must be dropped
    start_prog();
    for (int i = 0; i < 16; i++) enter(16'(i), 1'b0);
    chk("full_16", {31'd0, full}, 32'd1);
    chk("led_16", {16'd0, led}, 32'hFFFF);
    enter(16'hDEAD, 1'b0);
    chk("full_17", {31'd0, full}, 32'd1);
    exit_prog();
    chk("msg_len_16", {27'd0, msg_len}, 32'd16);
    chk("len_valid_16", {31'd0, len_valid}, 32'd1);

    // Three-word message, then an empty session keeps it
    start_prog();
    enter(16'hA001, 1'b0);
    enter(16'hA002, 1'b0);
    enter(16'hA003, 1'b0);
    exit_prog();
    start_prog();
    tick();
    exit_prog();
    chk("empty_msg_len", {27'd0, msg_len}, 32'd3);
    chk("empty_len_valid", {31'd0, len_valid}, 32'd1);
    run_clear();

    // Enter and prog_req fall in the same cycle: word is still committed
    start_prog();
    enter(16'h5555, 1'b0);
    enter(16'h6666, 1'b1);
    tick();
    chk("same_cycle_msg_len", {27'd0, msg_len}, 32'd2);
    chk("same_cycle_len_valid", {31'd0, len_valid}, 32'd1);

    // Clear with prog_req also high in IDLE: clear wins
    prog_req = 1'b1;
    run_clear();

    // clear_req in PROG has no effect
    start_prog();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("prog_clear_ignored", {31'd0, prog_active}, 32'd1);
    chk("prog_clear_busy", {31'd0, busy}, 32'd0);
    enter(16'h7777, 1'b0);
    exit_prog();
    chk("one_word_msg_len", {27'd0, msg_len}, 32'd1);

    // Reset during clear at address 5
    for (int a = 0; a < 6; a++) exp_q.push_back({4'(a), 16'h0000});
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    chk("clear_addr5", {28'd0, mem_addr}, 32'd5);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_clear", {mem_en, mem_we, mem_addr, mem_din, msg_len, len_valid,
                            prog_active, busy, full, led}, '0);
    tick();
    chk("reset_hold", {mem_en, mem_we, mem_addr, mem_din, msg_len, len_valid,
                       prog_active, busy, full, led}, '0);
    reset = 1'b0;
    repeat (3) tick();
    chk("after_reset_busy", {31'd0, busy}, 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
